// File: rtl/if_resp.sv
// if_resp: SPU instruction-fetch response stage.
//
// Turns a fetch request from the PC register into one local-store read. The
// returned doubleword is registered as a two-instruction bundle for decode.
// A branch flush discards in-flight data. If the local store does not answer
// within TIMEOUT cycles, the request is abandoned and a sticky error is raised.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   pc, ce             fetch address / fetch enable from the PC register
//   stall_i            decode is not consuming the current bundle
//   branch_flush_i     discard all fetched and in-flight instructions
//   ls_rd_req, ls_addr local-store read request and doubleword address
//   ls_ack, ls_data    local-store completion and 64-bit read data
//   inst0_o, inst1_o   even / odd instruction of the bundle
//   inst_pc_o          doubleword-aligned PC of the bundle
//   inst_valid_o       bundle valid
//   busy_o             a local-store request is outstanding
//   ls_err_o           sticky timeout flag
//   fetch_cnt_o        number of bundles delivered (wraps)
module if_resp #(
  parameter int LS_ADDR_W = 15,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:31]            pc,
  input  logic                   ce,
  input  logic                   stall_i,
  input  logic                   branch_flush_i,
  output logic                   ls_rd_req,
  output logic [0:LS_ADDR_W-1]   ls_addr,
  input  logic                   ls_ack,
  input  logic [0:63]            ls_data,
  output logic [0:31]            inst0_o,
  output logic [0:31]            inst1_o,
  output logic [0:31]            inst_pc_o,
  output logic                   inst_valid_o,
  output logic                   busy_o,
  output logic                   ls_err_o,
  output logic [0:15]            fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [0:31]          req_pc_q, req_pc_d;
  logic [0:LS_ADDR_W-1] ls_addr_q, ls_addr_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic                 err_q, err_d;
  logic                 ls_rd_req_q, ls_rd_req_d;
  logic                 busy_q, busy_d;
  logic [0:31]          inst0_q, inst0_d;
  logic [0:31]          inst1_q, inst1_d;
  logic [0:31]          inst_pc_q, inst_pc_d;
  logic                 inst_valid_q, inst_valid_d;
  logic [0:15]          fetch_cnt_q, fetch_cnt_d;
  logic                 deliver_s;
  logic                 out_free_s;
  logic                 unused_pc_s;

  // The output register can take a new bundle if it is empty or being consumed now.
  assign out_free_s  = !inst_valid_q || !stall_i;
  // Byte-within-doubleword bits of pc play no part in the fetch.
  assign unused_pc_s = ^pc[29:31];

  // Next-state logic for the request FSM and the bundle output register.
  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    ls_addr_d    = ls_addr_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    inst0_d      = inst0_q;
    inst1_d      = inst1_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    deliver_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ce && !branch_flush_i && out_free_s) begin
          state_d    = S_REQ;
          req_pc_d   = {pc[0:28], 3'b000};
          ls_addr_d  = pc[29-LS_ADDR_W:28];
          wait_cnt_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (ls_ack) begin
          // A flush arriving with the ack discards the data.
          state_d    = S_IDLE;
          wait_cnt_d = 8'd0;
          if (!branch_flush_i) begin
            deliver_s = 1'b1;
          end else begin
            deliver_s = 1'b0;
          end
        end else if (branch_flush_i) begin
          // The read cannot be cancelled; wait for its ack and discard it.
          state_d    = S_DROP;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_IDLE;
          wait_cnt_d = 8'd0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DROP: begin
        // Further flushes here change nothing; only ack or timeout leave.
        if (ls_ack) begin
          state_d    = S_IDLE;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_IDLE;
          wait_cnt_d = 8'd0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase

    if (branch_flush_i) begin
      inst_valid_d = 1'b0;
    end else if (deliver_s) begin
      inst0_d      = ls_data[0:31];
      inst1_d      = ls_data[32:63];
      inst_pc_d    = req_pc_q;
      inst_valid_d = 1'b1;
      fetch_cnt_d  = fetch_cnt_q + 16'd1;
    end else if (inst_valid_q && !stall_i) begin
      inst_valid_d = 1'b0;
    end else begin
      inst_valid_d = inst_valid_q;
    end

    ls_rd_req_d = (state_d == S_REQ) || (state_d == S_DROP);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == 1'b0) begin
      state_q      <= S_IDLE;
      req_pc_q     <= 32'd0;
      ls_addr_q    <= '0;
      wait_cnt_q   <= 8'd0;
      err_q        <= 1'b0;
      ls_rd_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      inst0_q      <= 32'd0;
      inst1_q      <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      fetch_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      ls_addr_q    <= ls_addr_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      ls_rd_req_q  <= ls_rd_req_d;
      busy_q       <= busy_d;
      inst0_q      <= inst0_d;
      inst1_q      <= inst1_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign ls_rd_req    = ls_rd_req_q;
  assign ls_addr      = ls_addr_q;
  assign inst0_o      = inst0_q;
  assign inst1_o      = inst1_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign busy_o       = busy_q;
  assign ls_err_o     = err_q;
  assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_if_resp.sv
// tb_if_resp: testbench for if_resp.
//
// Directed scenarios cover reset, a basic fetch, stall hold, flush with a
// late ack, flush together with an ack, timeout and reset mid-request. These
// are followed by a long randomized run. Every cycle, all DUT outputs are
// compared against a transaction-level reference model.
module tb_if_resp;

  localparam int TO  = 4;
  localparam int AW  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:31]   pc;
  logic          ce;
  logic          stall_i;
  logic          branch_flush_i;
  logic          ls_rd_req;
  logic [0:AW-1] ls_addr;
  logic          ls_ack;
  logic [0:63]   ls_data;
  logic [0:31]   inst0_o;
  logic [0:31]   inst1_o;
  logic [0:31]   inst_pc_o;
  logic          inst_valid_o;
  logic          busy_o;
  logic          ls_err_o;
  logic [0:15]   fetch_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a request is either outstanding or not, and it is
  // either wanted or already flushed. Age counts cycles spent without an ack.
  bit          m_out;
  bit          m_disc;
  int          m_age;
  logic [31:0] m_reqpc;
  logic [14:0] m_addr;
  logic [31:0] m_i0, m_i1, m_ipc;
  logic        m_valid;
  logic        m_err;
  logic [15:0] m_cnt;

  if_resp #(.LS_ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .ce             (ce),
    .stall_i        (stall_i),
    .branch_flush_i (branch_flush_i),
    .ls_rd_req      (ls_rd_req),
    .ls_addr        (ls_addr),
    .ls_ack         (ls_ack),
    .ls_data        (ls_data),
    .inst0_o        (inst0_o),
    .inst1_o        (inst1_o),
    .inst_pc_o      (inst_pc_o),
    .inst_valid_o   (inst_valid_o),
    .busy_o         (busy_o),
    .ls_err_o       (ls_err_o),
    .fetch_cnt_o    (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ls_rd_req", 64'(ls_rd_req), 64'(m_out));
    chk("busy", 64'(busy_o), 64'(m_out));
    chk("ls_addr", 64'(ls_addr), 64'(m_addr));
    chk("inst_valid", 64'(inst_valid_o), 64'(m_valid));
    chk("inst0", 64'(inst0_o), 64'(m_i0));
    chk("inst1", 64'(inst1_o), 64'(m_i1));
    chk("inst_pc", 64'(inst_pc_o), 64'(m_ipc));
    chk("ls_err", 64'(ls_err_o), 64'(m_err));
    chk("fetch_cnt", 64'(fetch_cnt_o), 64'(m_cnt));
  endtask

  // Advance the model by one clock given the inputs applied for this cycle.
  task automatic model_step(input logic r, input logic c, input logic s, input logic f,
                            input logic a, input logic [31:0] p, input logic [63:0] d);
    bit free;
    bit dlv;
    if (!r) begin
      m_out = 0; m_disc = 0; m_age = 0; m_reqpc = 32'd0; m_addr = 15'd0;
      m_i0 = 32'd0; m_i1 = 32'd0; m_ipc = 32'd0; m_valid = 1'b0;
      m_err = 1'b0; m_cnt = 16'd0;
    end else begin
      free = !m_valid || !s;
      dlv  = 0;
      if (m_out) begin
        if (a) begin
          m_out = 0;
          dlv   = !m_disc && !f;
          m_disc = 0;
        end else if (f && !m_disc) begin
          m_disc = 1;
          m_age  = 0;
        end else if (m_age + 1 == TO) begin
          m_out  = 0;
          m_disc = 0;
          m_err  = 1'b1;
        end else begin
          m_age++;
        end
      end else if (c && !f && free) begin
        m_out   = 1;
        m_disc  = 0;
        m_age   = 0;
        m_reqpc = p & ~32'd7;
        m_addr  = 15'(p >> 3);
      end
      if (f) begin
        m_valid = 1'b0;
      end else if (dlv) begin
        m_i0    = d[63:32];
        m_i1    = d[31:0];
        m_ipc   = m_reqpc;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 16'd1;
      end else if (m_valid && !s) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare everything.
  task automatic cyc(input logic r, input logic c, input logic s, input logic f,
                     input logic a, input logic [31:0] p, input logic [63:0] d);
    rst = r; ce = c; stall_i = s; branch_flush_i = f; ls_ack = a; pc = p; ls_data = d;
    model_step(r, c, s, f, a, p, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [31:0] held_i0;

  initial begin
    rst = 1'b0; ce = 1'b0; stall_i = 1'b0; branch_flush_i = 1'b0;
    ls_ack = 1'b0; pc = 32'd0; ls_data = 64'd0;
    m_valid = 1'b1; m_err = 1'b1;

    // Reset, with a stray ack that must be ignored.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 64'hDEAD_BEEF_DEAD_BEEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_cnt", 64'(fetch_cnt_o), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 64'h1234);

    // Basic fetch, ack on third request cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0108, 64'd0);
    chk("d_addr", 64'(ls_addr), 64'h21);
    chk("d_req", 64'(ls_rd_req), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 64'h1111_1111_2222_2222);
    chk("d_i0", 64'(inst0_o), 64'h1111_1111);
    chk("d_i1", 64'(inst1_o), 64'h2222_2222);
    chk("d_ipc", 64'(inst_pc_o), 64'h108);
    chk("d_cnt", 64'(fetch_cnt_o), 64'd1);
    chk("d_valid", 64'(inst_valid_o), 64'd1);

    // Stall holds the bundle and blocks new requests.
    held_i0 = inst0_o;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 64'd0);
      chk("st_hold", 64'(inst0_o), 64'(held_i0));
      chk("st_noreq", 64'(ls_rd_req), 64'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 64'd0);
    chk("st_req", 64'(ls_rd_req), 64'd1);
    chk("st_val0", 64'(inst_valid_o), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 64'hAAAA_0001_BBBB_0002);
    chk("st_cnt", 64'(fetch_cnt_o), 64'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);

    // Flush in 2nd request cycle, ack 3 cycles later.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 64'd0);
    chk("fl_drop_req", 64'(ls_rd_req), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 64'h5555_5555_6666_6666);
    chk("fl_valid", 64'(inst_valid_o), 64'd0);
    chk("fl_busy", 64'(busy_o), 64'd0);
    chk("fl_cnt", 64'(fetch_cnt_o), 64'd2);

    // Flush and ack in the same cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 64'h7777_7777_8888_8888);
    chk("fa_valid", 64'(inst_valid_o), 64'd0);
    chk("fa_busy", 64'(busy_o), 64'd0);

    // Timeout after TO request cycles.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 64'd0);
    for (int i = 0; i < TO - 1; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
      chk("to_req", 64'(ls_rd_req), 64'd1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    chk("to_err", 64'(ls_err_o), 64'd1);
    chk("to_noreq", 64'(ls_rd_req), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 64'd0);
    chk("to_sticky", 64'(ls_err_o), 64'd1);

    // Reset during a request; late ack ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
    chk("rr_req", 64'(ls_rd_req), 64'd0);
    chk("rr_err", 64'(ls_err_o), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 64'h9999_9999_9999_9999);
    chk("rr_valid", 64'(inst_valid_o), 64'd0);
    chk("rr_cnt", 64'(fetch_cnt_o), 64'd0);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
          $urandom(),
          {$urandom(), $urandom()});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
